// File: rtl/fetch_pkg.sv
// Shared definitions for the 4-bit-PC fetch path: opcode classes, FSM state codes and
// width defaults. Also used by the core's next-PC logic.
package fetch_pkg;

  localparam int unsigned DefaultPcW  = 4;
  localparam int unsigned DefaultInsW = 8;

  localparam logic [3:0] OP_HALT = 4'b1100;

  // Bit n set means opcode n advances sequentially: 0100..1011 and 1101.
  localparam logic [15:0] OP_SEQ_MASK = 16'h2FF0;

  typedef logic [2:0] fetch_state_t;

  localparam fetch_state_t StIdle      = 3'd0;
  localparam fetch_state_t StFetch     = 3'd1;
  localparam fetch_state_t StIssue     = 3'd2;
  localparam fetch_state_t StWaitRedir = 3'd3;
  localparam fetch_state_t StHalt      = 3'd4;

  typedef enum logic [1:0] {
    OpClsSeq,
    OpClsCtrl,
    OpClsHalt
  } op_class_t;

  function automatic op_class_t classify_op(input logic [3:0] op);
    op_class_t cls;
    if (op == OP_HALT) begin
      cls = OpClsHalt;
    end else if (OP_SEQ_MASK[op]) begin
      cls = OpClsSeq;
    end else begin
      cls = OpClsCtrl;
    end
    return cls;
  endfunction

endpackage

// File: rtl/op_class_dec.sv
// Opcode-field classifier: instr[6:3] -> SEQ / CTRL / HALT. Purely combinational so the
// core's next-PC logic can share it.
module op_class_dec
  import fetch_pkg::*;
(
  input  logic [3:0] op,
  output op_class_t  op_class
);

  always_comb begin
    op_class = classify_op(op);
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: owns the PC, fetches bytes over req/ack and issues them to the
// core over valid/ready, stopping on control-flow or HALT opcodes until the core redirects.
module instr_fetch_seq
  import fetch_pkg::*;
#(
  parameter int unsigned      PC_W     = DefaultPcW,
  parameter int unsigned      INS_W    = DefaultInsW,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,

  output logic             mem_req,
  output logic [PC_W-1:0]  mem_addr,
  input  logic             mem_ack,
  input  logic [INS_W-1:0] mem_data,

  output logic             ins_valid,
  input  logic             ins_ready,
  output logic [INS_W-1:0] ins_data,
  output logic [PC_W-1:0]  ins_pc,

  input  logic             redir_valid,
  input  logic [PC_W-1:0]  redir_pc,
  output logic             halted
);

  localparam logic [PC_W-1:0] PcOne = PC_W'(1);

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             mem_req_q, mem_req_d;
  logic [PC_W-1:0]  mem_addr_q, mem_addr_d;
  logic             ins_valid_q, ins_valid_d;
  logic [INS_W-1:0] ins_data_q, ins_data_d;
  logic [PC_W-1:0]  ins_pc_q, ins_pc_d;
  logic             halted_q, halted_d;
  logic             squash_q, squash_d;

  op_class_t        op_class;
  logic             transfer;

  op_class_dec u_op_class_dec (
    .op       (ins_data_q[6:3]),
    .op_class (op_class)
  );

  assign transfer = ins_valid_q & ins_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    ins_valid_d = ins_valid_q;
    ins_data_d  = ins_data_q;
    ins_pc_d    = ins_pc_q;
    halted_d    = halted_q;
    squash_d    = squash_q;

    if (redir_valid) begin
      // Redirect overrides everything; a pending instruction is dropped.
      pc_d        = redir_pc;
      ins_valid_d = 1'b0;
      halted_d    = 1'b0;
      state_d     = StFetch;
      if (mem_req_q) begin
        // The bus request cannot be withdrawn: let it complete and discard its byte.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          squash_d  = 1'b0;
        end else begin
          squash_d  = 1'b1;
        end
      end else begin
        mem_req_d  = 1'b1;
        mem_addr_d = redir_pc;
        squash_d   = 1'b0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StFetch;
        end

        StFetch: begin
          if (mem_req_q) begin
            if (mem_ack) begin
              mem_req_d = 1'b0;
              if (squash_q) begin
                squash_d = 1'b0;
              end else begin
                ins_valid_d = 1'b1;
                ins_data_d  = mem_data;
                ins_pc_d    = mem_addr_q;
                state_d     = StIssue;
              end
            end
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
          end
        end

        StIssue: begin
          if (transfer) begin
            ins_valid_d = 1'b0;
            case (op_class)
              OpClsSeq: begin
                pc_d    = pc_q + PcOne;
                state_d = StFetch;
              end
              OpClsHalt: begin
                halted_d = 1'b1;
                state_d  = StHalt;
              end
              default: begin
                state_d = StWaitRedir;
              end
            endcase
          end
        end

        StWaitRedir, StHalt: begin
          // Only a redirect leaves these states.
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= RESET_PC;
      ins_valid_q <= 1'b0;
      ins_data_q  <= '0;
      ins_pc_q    <= RESET_PC;
      halted_q    <= 1'b0;
      squash_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      ins_valid_q <= ins_valid_d;
      ins_data_q  <= ins_data_d;
      ins_pc_q    <= ins_pc_d;
      halted_q    <= halted_d;
      squash_q    <= squash_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign ins_valid = ins_valid_q;
  assign ins_data  = ins_data_q;
  assign ins_pc    = ins_pc_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: directed timing steps followed by a random run, with a ROM model
// and a program-level reference (expected PC stream, waiting/halted status).
module tb_instr_fetch_seq;

  logic       clk;
  logic       rst;
  logic       mem_req;
  logic [3:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_data;
  logic       ins_valid;
  logic       ins_ready;
  logic [7:0] ins_data;
  logic [3:0] ins_pc;
  logic       redir_valid;
  logic [3:0] redir_pc;
  logic       halted;

  instr_fetch_seq #(
    .PC_W     (4),
    .INS_W    (8),
    .RESET_PC (4'd0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .ins_data    (ins_data),
    .ins_pc      (ins_pc),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] rom [16];
  int         lat_fixed = 1;
  int         cur_lat   = 1;
  int         req_age   = 0;

  // Program-level reference state.
  logic [3:0] exp_pc;
  bit         m_waiting;
  bit         m_halted;
  int         n_xfer = 0;

  bit         prev_req, prev_ack, prev_valid, prev_xfer, prev_redir;
  logic [3:0] prev_addr, prev_ins_pc;
  logic [7:0] prev_ins_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // 0 = sequential, 1 = control (wait for redirect), 2 = halt
  function automatic int cls(input logic [7:0] ins);
    logic [3:0] op;
    op = ins[6:3];
    case (op)
      4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000,
      4'b1001, 4'b1010, 4'b1011, 4'b1101: return 0;
      4'b1100: return 2;
      default: return 1;
    endcase
  endfunction

  task automatic set_lat(input int n);
    lat_fixed = n;
    cur_lat   = (n > 0) ? n : int'($urandom_range(1, 3));
    req_age   = 0;
  endtask

  task automatic model_reset();
    exp_pc     = 4'd0;
    m_waiting  = 1'b0;
    m_halted   = 1'b0;
    prev_req   = 1'b0;
    prev_ack   = 1'b0;
    prev_valid = 1'b0;
    prev_xfer  = 1'b0;
    prev_redir = 1'b0;
    req_age    = 0;
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_mem_req"},   mem_req,   0);
    check({pfx, "_ins_valid"}, ins_valid, 0);
    check({pfx, "_halted"},    halted,    0);
    check({pfx, "_mem_addr"},  mem_addr,  0);
    check({pfx, "_ins_pc"},    ins_pc,    0);
    check({pfx, "_ins_data"},  ins_data,  0);
  endtask

  // One cycle: at the falling edge check protocol invariants, answer the memory, then drive
  // the core-side inputs for the next rising edge and advance the reference.
  task automatic step(input bit rdy, input bit rv, input logic [3:0] rpc);
    bit xfer;
    bit ack;
    @(negedge clk);
    check("halted", halted, m_halted);
    if (m_waiting) begin
      check("idle_req",   mem_req,   0);
      check("idle_valid", ins_valid, 0);
    end
    if (prev_ack) begin
      check("req_drop", mem_req, 0);
    end else if (prev_req) begin
      check("req_hold",  mem_req,  1);
      check("addr_hold", mem_addr, prev_addr);
    end
    if (prev_valid && !prev_xfer && !prev_redir) begin
      check("valid_hold", ins_valid, 1);
      check("data_hold",  ins_data,  prev_ins_data);
      check("pc_hold",    ins_pc,    prev_ins_pc);
    end

    ack = 1'b0;
    if (mem_req === 1'b1 && !prev_ack) begin
      req_age++;
      if (req_age >= cur_lat) begin
        ack     = 1'b1;
        req_age = 0;
        cur_lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3));
      end
    end else begin
      req_age = 0;
    end
    mem_ack     = ack;
    mem_data    = ack ? rom[mem_addr] : 8'($urandom);
    ins_ready   = rdy;
    redir_valid = rv;
    redir_pc    = rpc;

    xfer = (ins_valid === 1'b1) && rdy && !rv;
    if (rv) begin
      exp_pc    = rpc;
      m_waiting = 1'b0;
      m_halted  = 1'b0;
    end else if (xfer) begin
      check("xfer_pc",   ins_pc,   exp_pc);
      check("xfer_data", ins_data, rom[exp_pc]);
      n_xfer++;
      case (cls(rom[exp_pc]))
        0: exp_pc = 4'((32'(exp_pc) + 1) % 16);
        2: begin
          m_waiting = 1'b1;
          m_halted  = 1'b1;
        end
        default: m_waiting = 1'b1;
      endcase
    end

    prev_req      = (mem_req === 1'b1);
    prev_ack      = ack;
    prev_addr     = mem_addr;
    prev_valid    = (ins_valid === 1'b1);
    prev_xfer     = xfer;
    prev_redir    = rv;
    prev_ins_data = ins_data;
    prev_ins_pc   = ins_pc;
  endtask

  initial begin
    bit         r_rv, r_rdy;
    logic [3:0] r_pc;
    int         wait_cnt, wait_thr, stall, max_stall, nx, n0;

    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0]  = 8'h20;
    rom[1]  = 8'h20;
    rom[2]  = 8'h60;
    rom[4]  = 8'h20;
    rom[7]  = 8'h38;
    rom[9]  = 8'h00;
    rom[15] = 8'h48;

    rst         = 1'b1;
    ins_ready   = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = 4'd0;
    mem_ack     = 1'b0;
    mem_data    = 8'h00;

    #3 rst = 1'b0;
    #1 check_reset("por");
    set_lat(1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Reset release: one IDLE cycle, request on the second edge, ack one cycle later.
    step(0, 0, 0);
    check("idle_no_req", mem_req, 0);
    step(0, 0, 0);
    check("first_req",  mem_req,  1);
    check("first_addr", mem_addr, 0);
    step(1, 0, 0);
    check("first_valid",  ins_valid, 1);
    check("first_data",   ins_data,  8'h20);
    check("first_pc",     ins_pc,    0);
    check("issue_no_req", mem_req,   0);
    step(1, 0, 0);
    check("valid_clear", ins_valid, 0);
    step(1, 0, 0);
    check("seq_req",  mem_req,  1);
    check("seq_addr", mem_addr, 1);

    // Addr 1 sequential, addr 2 HALT.
    repeat (4) step(1, 0, 0);
    step(0, 0, 0);
    check("halt_set",    halted,  1);
    check("halt_no_req", mem_req, 0);
    repeat (3) begin
      step(0, 0, 0);
      check("halt_quiet", mem_req, 0);
    end
    step(0, 1, 2);
    step(0, 0, 0);
    check("unhalt",     halted,   0);
    check("redir_req",  mem_req,  1);
    check("redir_addr", mem_addr, 2);

    // Redirect while issuing drops the byte even with ready high.
    step(1, 1, 15);
    check("drop_pre_valid", ins_valid, 1);
    check("drop_pre_data",  ins_data,  8'h60);
    step(0, 0, 0);
    check("drop_valid", ins_valid, 0);
    check("drop_req",   mem_req,   1);
    check("drop_addr",  mem_addr,  15);
    rom[2] = 8'h20;
    rom[3] = 8'h00;
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    check("wrap_req",  mem_req,  1);
    check("wrap_addr", mem_addr, 0);

    // 0,1,2 sequential then CTRL at 3.
    for (int k = 0; k < 40 && !m_waiting; k++) step(1, 0, 0);
    check("ctrl_pc",   ins_pc,   3);
    check("ctrl_data", ins_data, 8'h00);
    repeat (5) begin
      step(1, 0, 0);
      check("ctrl_no_req", mem_req, 0);
    end
    step(0, 1, 9);
    step(0, 0, 0);
    check("ctrl_redir_req",  mem_req,  1);
    check("ctrl_redir_addr", mem_addr, 9);
    step(1, 0, 0);
    check("ctrl9_pc", ins_pc, 9);
    step(0, 0, 0);

    // Redirect to 7 while the request to 4 waits three cycles for its ack.
    set_lat(3);
    step(0, 1, 4);
    step(0, 1, 7);
    check("sq_req",  mem_req,  1);
    check("sq_addr", mem_addr, 4);
    step(0, 0, 0);
    check("sq_addr_mid",  mem_addr,  4);
    check("sq_valid_mid", ins_valid, 0);
    step(0, 0, 0);
    check("sq_addr_ack", mem_addr, 4);
    check("sq_req_ack",  mem_req,  1);
    step(0, 0, 0);
    check("sq_no_valid", ins_valid, 0);
    check("sq_req_drop", mem_req,   0);
    step(0, 0, 0);
    check("sq_new_req",  mem_req,  1);
    check("sq_new_addr", mem_addr, 7);

    for (int k = 0; k < 10 && ins_valid !== 1'b1; k++) step(0, 0, 0);
    check("hold_valid", ins_valid, 1);
    check("hold_pc",    ins_pc,    7);
    check("hold_data",  ins_data,  8'h38);
    repeat (4) begin
      step(0, 0, 0);
      check("hold_no_req", mem_req, 0);
      check("hold_stable", {ins_valid, ins_pc, ins_data}, {1'b1, 4'd7, 8'h38});
    end

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset("async");
    @(negedge clk);
    mem_ack     = 1'b0;
    ins_ready   = 1'b0;
    redir_valid = 1'b0;
    rst         = 1'b1;
    model_reset();

    // Random program, random latency, backpressure and redirects.
    set_lat(0);
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    wait_cnt  = 0;
    wait_thr  = 2;
    stall     = 0;
    max_stall = 0;
    n0        = n_xfer;
    for (int c = 0; c < 1500; c++) begin
      r_rdy = ($urandom_range(0, 3) != 0);
      r_pc  = 4'($urandom_range(0, 15));
      r_rv  = 1'b0;
      if (m_waiting) begin
        wait_cnt++;
        if (wait_cnt >= wait_thr) begin
          r_rv     = 1'b1;
          wait_cnt = 0;
          wait_thr = int'($urandom_range(1, 4));
        end
      end else if ($urandom_range(0, 24) == 0) begin
        r_rv = 1'b1;
      end
      nx = n_xfer;
      step(r_rdy, r_rv, r_pc);
      if (r_rv || n_xfer != nx || m_waiting) stall = 0;
      else stall++;
      if (stall > max_stall) max_stall = stall;
    end
    check("stall_bound", (max_stall <= 60), 1);
    check("deliveries",  ((n_xfer - n0) >= 100), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_seq.md
# instr_fetch_seq

Instruction fetch sequencer for the 4-bit-PC / 8-bit-instruction core: owns the program counter, reads instruction bytes from program memory over a req/ack interface, and hands each instruction to the core over a valid/ready interface. It is the producer side of the next-PC logic. It classifies every delivered instruction by opcode field `[6:3]` to decide whether to advance sequentially, wait for a core redirect, or halt.

## Interface
- `PC_W`, 4, program counter / memory address width
- `INS_W`, 8, instruction width
- `RESET_PC`, 0, PC value loaded on reset
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `mem_req`  out  1  fetch request; held until `mem_ack`
- `mem_addr`  out  PC_W  fetch address; stable while `mem_req`
- `mem_ack`  in  1  memory response strobe, 1 cycle
- `mem_data`  in  INS_W  instruction byte, valid with `mem_ack`
- `ins_valid`  out  1  instruction available to core
- `ins_ready`  in  1  core accepts instruction
- `ins_data`  out  INS_W  instruction byte
- `ins_pc`  out  PC_W  address of `ins_data`
- `redir_valid`  in  1  core redirect strobe
- `redir_pc`  in  PC_W  redirect target
- `halted`  out  1  fetch stopped on HALT opcode

## Operation
- Opcode `op = instr[6:3]`. Classes:
  - SEQ: 0100, 0101, 0110, 0111, 1000, 1001, 1010, 1011, 1101.
  - HALT: 1100.
  - CTRL: all others (0000–0011, 1110, 1111).
- States: IDLE, FETCH, ISSUE, WAIT_REDIR, HALT.
  - IDLE → FETCH: unconditional.
  - FETCH → ISSUE: on `mem_ack`, unless squashed; capture `mem_data`.
  - ISSUE → FETCH: transfer of a SEQ instruction; `pc <= pc + 1`, modulo 2^PC_W, so 15 wraps to 0.
  - ISSUE → WAIT_REDIR: transfer of a CTRL instruction.
  - ISSUE → HALT: transfer of a HALT instruction.
  - WAIT_REDIR, HALT → FETCH: on `redir_valid`.
- Transfer is `ins_valid & ins_ready`.
- Redirect is accepted in every state and has priority over all other events. It loads `pc <= redir_pc`.
  - In ISSUE: the instruction is dropped, even if `ins_ready` is high the same cycle.
  - In FETCH with a request outstanding: the request stays unchanged until `mem_ack`. The returned byte is discarded via a squash flag, then a new request issues at `redir_pc`.
  - In FETCH before a request has issued: the new PC is used directly.
- Back-to-back redirects: the last one wins. The squash flag stays set until the outstanding ack arrives.
- Reset, including mid-operation, forces all outputs to reset values immediately and enters IDLE.

## Timing
- All outputs are registered.
- Reset values:
  - `mem_req`, `ins_valid`, `halted` = 0.
  - `mem_addr`, `ins_pc` = RESET_PC.
  - `ins_data` = 0.
- First `mem_req` is asserted in the 2nd rising edge after `rst` deasserts (IDLE lasts 1 cycle).
- `mem_ack` arrives ≥1 cycle after `mem_req`. `mem_req` drops and `ins_valid` rises on the edge following `mem_ack`.
- `ins_valid`, `ins_data` and `ins_pc` hold stable until transfer or redirect. There is no combinational path from `ins_ready` to any output.
- After a SEQ transfer, `mem_req` reasserts with `pc + 1` on the next edge.
- Sequential throughput: 1 instruction per 3 cycles with a 1-cycle-ack memory.
- `halted` rises on the edge after a HALT transfer. It clears on the edge after `redir_valid`, together with `mem_req` rising.
- Redirect latency: `mem_req` at `redir_pc` on the next edge, or the edge after the squashed ack.

## Structure
- Shared package `fetch_pkg`:
  - opcode constants (`OP_HALT = 4'b1100`, SEQ list)
  - state enum
  - op-class enum (SEQ, CTRL, HALT)
  - PC_W / INS_W defaults
- One combinational sub-module, `op_class_dec`: `instr[6:3]` → class. It is reused by the core's next-PC logic.

## Test plan
- Reset release, ROM acks 1 cycle after request with 0x20 (op 0100) at addr 0 → `ins_data` = 0x20, `ins_pc` = 0; next `mem_addr` = 1.
- Redirect to 15; ROM returns 0x48 (op 1001) → after transfer `mem_addr` = 0 (wrap).
- Addr 3 returns 0x00 (CTRL) → after transfer `mem_req` stays 0 for 5 cycles; `redir_pc` = 9 → next `mem_addr` = 9.
- Addr 2 returns 0x60 (HALT) → `halted` = 1 with no requests; `redir_valid`, `redir_pc` = 2 → `halted` = 0 and `mem_addr` = 2.
- Redirect to 7 while the request to addr 4 is outstanding, ack 3 cycles later → no `ins_valid` for that byte, `mem_addr` 4 stays stable until ack, then request at 7.
- `ins_ready` low for 4 cycles → outputs stable and no `mem_req`; then `rst` low mid-hold → `ins_valid` = 0 and `mem_addr` = 0 immediately, without waiting for a clock.
